// File: rtl/rifl_rx_pkt_guard_pkg.sv
// Shared types and helpers for the RIFL receive packet guard:
// FSM state encoding, tkeep legality check and the terminator keep value.
package rifl_rx_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  // Widest keep vector any lane configuration may hand to keep_legal().
  localparam int KEEP_MAX_W = 512;

  localparam logic [KEEP_MAX_W-1:0] KEEP_ONE  = KEEP_MAX_W'(1);
  localparam logic [KEEP_MAX_W-1:0] TERM_KEEP = KEEP_ONE;

  // Non-last beats must be full; a last beat must be 2^n-1 with 1 <= n <= nbytes.
  function automatic logic keep_legal(
    input logic [KEEP_MAX_W-1:0] keep,
    input logic                  last,
    input int                    nbytes
  );
    logic [KEEP_MAX_W-1:0] full;
    full = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      full[i] = (i < nbytes);
    end
    if (!last) begin
      return keep == full;
    end
    return keep[0] && ((keep & (keep + KEEP_ONE)) == '0) && ((keep & ~full) == '0);
  endfunction

endpackage

// File: rtl/rifl_rx_pkt_guard_if.sv
// Packed per-lane AXI-Stream bundle (payload, keep, last, user, valid/ready).
interface rifl_rx_pkt_guard_if #(
  parameter int PAYLOAD_WIDTH = 240
) ();
  logic [PAYLOAD_WIDTH-1:0]   tdata;
  logic [PAYLOAD_WIDTH/8-1:0] tkeep;
  logic                       tlast;
  logic                       tuser;
  logic                       tvalid;
  logic                       tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/rifl_axis_skid.sv
// Generic two-entry AXI-Stream register slice; in_ready is a pure register so
// there is no combinational path from out_ready back to the producer.
module rifl_axis_skid #(
  parameter int DATA_W = 240,
  parameter int KEEP_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  input  logic              in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              out_user
);
  localparam int BUS_W = DATA_W + KEEP_W + 2;

  logic [BUS_W-1:0] in_bus;
  logic [BUS_W-1:0] out_bus_reg;
  logic [BUS_W-1:0] skid_bus_reg;
  logic             out_valid_reg;
  logic             skid_valid_reg;
  logic             in_ready_reg;
  logic             push;

  assign in_bus = {in_data, in_keep, in_last, in_user};
  assign push   = in_valid && in_ready_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bus_reg    <= '0;
      skid_bus_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else if (!out_valid_reg || out_ready) begin
      // Output slot frees up: the skid entry (if any) is always older than the input.
      if (skid_valid_reg) begin
        out_bus_reg    <= skid_bus_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= push;
        if (push) begin
          out_bus_reg <= in_bus;
        end
      end
      in_ready_reg <= 1'b1;
    end else if (push) begin
      skid_bus_reg   <= in_bus;
      skid_valid_reg <= 1'b1;
      in_ready_reg   <= 1'b0;
    end else begin
      in_ready_reg <= !skid_valid_reg;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign {out_data, out_keep, out_last, out_user} = out_bus_reg;

endmodule

// File: rtl/rifl_rx_pkt_guard.sv
// RIFL receive packet guard: enforces framing/keep rules and link-loss termination.
// Optional statistics counters are built only when RIFL_RX_PKT_STATS_EN is defined.
module rifl_rx_pkt_guard
  import rifl_rx_pkt_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 240,
  parameter int MAX_BEATS     = 64,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_up,
  rifl_rx_pkt_guard_if.slave      s_axis,
  rifl_rx_pkt_guard_if.master     m_axis,
  output logic                    pkt_err,
  output logic [STAT_WIDTH-1:0]   pkt_cnt,
  output logic [STAT_WIDTH-1:0]   err_cnt
);
  localparam int KEEP_W = PAYLOAD_WIDTH / 8;
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  state_t                   state_reg, state_next;
  logic [BEAT_W-1:0]        beat_cnt_reg, beat_cnt_next;
  logic                     rx_up_d_reg;

  logic                     skid_ready;
  logic                     push_valid;
  logic [PAYLOAD_WIDTH-1:0] push_data;
  logic [KEEP_W-1:0]        push_keep;
  logic                     push_last;
  logic                     push_user;

  logic                     s_hs;
  logic                     m_hs_last;
  logic                     keep_ok;
  logic                     max_hit;
  logic [BEAT_W-1:0]        beat_num;

  // DROP always sinks; FLUSH stalls the input while the terminator is queued.
  assign s_axis.tready = (state_reg == ST_DROP) || ((state_reg != ST_FLUSH) && skid_ready);
  assign s_hs          = s_axis.tvalid && s_axis.tready;

  assign beat_num = (state_reg == ST_IDLE) ? BEAT_W'(1) : beat_cnt_reg + BEAT_W'(1);
  assign keep_ok  = keep_legal(KEEP_MAX_W'(s_axis.tkeep), s_axis.tlast, KEEP_W);
  assign max_hit  = (beat_num == BEAT_W'(MAX_BEATS));

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    push_valid    = 1'b0;
    push_data     = s_axis.tdata;
    push_keep     = s_axis.tkeep;
    push_last     = s_axis.tlast;
    push_user     = 1'b0;
    case (state_reg)
      ST_IDLE, ST_PASS: begin
        if (s_hs) begin
          push_valid    = 1'b1;
          beat_cnt_next = beat_num;
          if (!keep_ok) begin
            push_last  = 1'b1;
            push_user  = 1'b1;
            state_next = s_axis.tlast ? ST_IDLE : ST_DROP;
          end else if (s_axis.tlast) begin
            state_next = ST_IDLE;
          end else if (max_hit) begin
            push_last  = 1'b1;
            push_user  = 1'b1;
            state_next = ST_DROP;
          end else begin
            state_next = (state_reg == ST_PASS && !rx_up) ? ST_FLUSH : ST_PASS;
          end
        end else if (state_reg == ST_PASS && !rx_up) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        push_valid = 1'b1;
        push_data  = '0;
        push_keep  = TERM_KEEP[KEEP_W-1:0];
        push_last  = 1'b1;
        push_user  = 1'b1;
        if (skid_ready) begin
          state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        // A fresh link session also ends the discard, even without a tlast.
        if ((s_hs && s_axis.tlast) || (rx_up && !rx_up_d_reg)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= '0;
      rx_up_d_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      rx_up_d_reg  <= rx_up;
    end
  end

  rifl_axis_skid #(
    .DATA_W (PAYLOAD_WIDTH),
    .KEEP_W (KEEP_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_valid),
    .in_ready  (skid_ready),
    .in_data   (push_data),
    .in_keep   (push_keep),
    .in_last   (push_last),
    .in_user   (push_user),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready),
    .out_data  (m_axis.tdata),
    .out_keep  (m_axis.tkeep),
    .out_last  (m_axis.tlast),
    .out_user  (m_axis.tuser)
  );

  assign m_hs_last = m_axis.tvalid && m_axis.tready && m_axis.tlast;
  assign pkt_err   = m_hs_last && m_axis.tuser;

`ifdef RIFL_RX_PKT_STATS_EN
  logic [STAT_WIDTH-1:0] pkt_cnt_reg;
  logic [STAT_WIDTH-1:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else if (m_hs_last) begin
      if (pkt_cnt_reg != '1) begin
        pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
      end
      if (m_axis.tuser && err_cnt_reg != '1) begin
        err_cnt_reg <= err_cnt_reg + 1'b1;
      end
    end
  end

  assign pkt_cnt = pkt_cnt_reg;
  assign err_cnt = err_cnt_reg;
`else
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rifl_rx_pkt_guard.sv
// Scoreboard bench for rifl_rx_pkt_guard: a packet-level model queues expected
// output beats at stimulus time; a negedge monitor pops and compares them.
module tb_rifl_rx_pkt_guard;
  localparam int PW   = 240;
  localparam int KW   = PW / 8;
  localparam int MAXB = 64;
  localparam int SW   = 32;

  typedef struct packed {
    logic [PW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_up = 1'b0;
  logic          pkt_err;
  logic [SW-1:0] pkt_cnt;
  logic [SW-1:0] err_cnt;

  rifl_rx_pkt_guard_if #(.PAYLOAD_WIDTH(PW)) s_if ();
  rifl_rx_pkt_guard_if #(.PAYLOAD_WIDTH(PW)) m_if ();

  rifl_rx_pkt_guard #(
    .PAYLOAD_WIDTH (PW),
    .MAX_BEATS     (MAXB),
    .STAT_WIDTH    (SW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_up   (rx_up),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .pkt_err (pkt_err),
    .pkt_cnt (pkt_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    exp_pkt = 0;
  int    exp_err = 0;
  int    out_beats = 0;
  bit    mon_en = 1'b1;
  bit    lat_en = 1'b0;
  bit    rdy_mode = 1'b0;
  beat_t expq[$];
  int    latq[$];

  localparam logic [KW-1:0] ALL1  = '1;
  localparam logic [KW-1:0] K7FFF = KW'(32'h7FFF);
  localparam logic [KW-1:0] K7FFE = KW'(32'h7FFE);

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #3;
    m_if.tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // s_axis_tready must not move after m_axis_tready changes mid-cycle.
  always @(posedge clk) begin
    logic t;
    #2;
    t = s_if.tready;
    @(negedge clk);
    if (rdy_mode && rst_n) chk("s_tready_registered", s_if.tready, t);
  end

  beat_t prev_out;
  bit    prev_stall = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    beat_t cur;
    int    t_in;
    cur = '{d: m_if.tdata, k: m_if.tkeep, l: m_if.tlast, u: m_if.tuser};
    if (rst_n && mon_en) begin
      if (prev_stall) begin
        chk("hold_valid", m_if.tvalid, 1'b1);
        chk("hold_beat", cur, prev_out);
      end
      if (m_if.tvalid && m_if.tready) begin
        out_beats++;
        $display("out beat %0d: keep=%h last=%0b user=%0b", out_beats, cur.k, cur.l, cur.u);
        if (expq.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          chk("tdata", cur.d, e.d);
          chk("tkeep", cur.k, e.k);
          chk("tlast", cur.l, e.l);
          chk("tuser", cur.u, e.u);
          chk("pkt_err", pkt_err, e.l & e.u);
        end
        if (lat_en) begin
          if (latq.size() == 0) chk("latency_missing_in", 1'b1, 1'b0);
          else begin
            t_in = latq.pop_front();
            chk("latency", 256'(cyc - t_in), 256'(1));
          end
        end
      end else begin
        chk("pkt_err_idle", pkt_err, 1'b0);
      end
      if (lat_en && s_if.tvalid && s_if.tready) latq.push_back(cyc);
    end
    prev_stall = rst_n && m_if.tvalid && !m_if.tready;
    prev_out   = cur;
  end

  function automatic beat_t mk(input logic [KW-1:0] k, input logic l);
    beat_t       b;
    logic [255:0] t;
    for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom;
    b.d = t[PW-1:0];
    b.k = k;
    b.l = l;
    b.u = 1'b0;
    return b;
  endfunction

  function automatic bit keep_ok(input logic [KW-1:0] k, input logic last);
    int n;
    n = $countones(k);
    if (!last) return n == KW;
    return (n >= 1) && (64'(k) == ((64'd1 << n) - 64'd1));
  endfunction

  // Packet-level reference: cut >= 0 means the link drops before beat index cut.
  task automatic model_pkt(input beat_t p[$], input int cut);
    beat_t o;
    for (int i = 0; i < p.size(); i++) begin
      if (i == cut) begin
        o = '{d: '0, k: KW'(1), l: 1'b1, u: 1'b1};
        expq.push_back(o); exp_pkt++; exp_err++;
        return;
      end
      o   = p[i];
      o.u = 1'b0;
      if (!keep_ok(p[i].k, p[i].l) || (i + 1 == MAXB && !p[i].l)) begin
        o.l = 1'b1; o.u = 1'b1;
        expq.push_back(o); exp_pkt++; exp_err++;
        return;
      end
      expq.push_back(o);
      if (p[i].l) begin
        exp_pkt++;
        return;
      end
    end
  endtask

  task automatic build(output beat_t p[$], input int n, input logic [KW-1:0] last_k,
                       input int bad_idx, input logic [KW-1:0] bad_k, input bit has_last);
    logic [KW-1:0] k;
    p = {};
    for (int i = 0; i < n; i++) begin
      k = (has_last && i == n - 1) ? last_k : ALL1;
      if (i == bad_idx) k = bad_k;
      p.push_back(mk(k, has_last && (i == n - 1)));
    end
  endtask

  task automatic drive(input beat_t b);
    bit rdy;
    int n;
    n = 0;
    s_if.tdata  = b.d;
    s_if.tkeep  = b.k;
    s_if.tlast  = b.l;
    s_if.tvalid = 1'b1;
    do begin
      @(negedge clk);
      rdy = s_if.tready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 1000);
    if (!rdy) chk("drive_timeout", 1'b1, 1'b0);
    #1 s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input beat_t p[$], input int cut);
    for (int i = 0; i < p.size(); i++) begin
      if (i == cut) begin
        repeat (2) @(posedge clk);
        #1 rx_up = 1'b0;
        repeat (4) @(posedge clk);
        #1;
      end
      drive(p[i]);
    end
  endtask

  task automatic run_pkt(input beat_t p[$], input int cut);
    model_pkt(p, cut);
    send_pkt(p, cut);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || m_if.tvalid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 256'(expq.size()), 256'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt();
`ifdef RIFL_RX_PKT_STATS_EN
    chk("pkt_cnt", pkt_cnt, 256'(exp_pkt));
    chk("err_cnt", err_cnt, 256'(exp_err));
`else
    chk("pkt_cnt_tied", pkt_cnt, 256'(0));
    chk("err_cnt_tied", err_cnt, 256'(0));
`endif
  endtask

  initial begin
    beat_t p[$];
    beat_t q[$];
    int    total;
    int    n;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tvalid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_m_tdata", m_if.tdata, 256'(0));
    chk("rst_m_tkeep", m_if.tkeep, 256'(0));
    chk("rst_m_tlast_tuser", {m_if.tlast, m_if.tuser}, 2'b00);
    chk("rst_s_tready", s_if.tready, 1'b0);
    chk("rst_pkt_err", pkt_err, 1'b0);
    chk_cnt();
    @(negedge clk) rst_n = 1'b1;
    #1 chk("s_tready_before_clk", s_if.tready, 1'b0);
    @(posedge clk);
    #1 chk("s_tready_after_clk", s_if.tready, 1'b1);
    rx_up = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Three back-to-back 4-beat packets: 1-cycle latency, no bubbles
    lat_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      build(p, 4, K7FFF, -1, '0, 1'b1);
      model_pkt(p, -1);
      q = {q, p};
    end
    send_pkt(q, -1);
    wait_drain();
    lat_en = 1'b0;
    chk_cnt();

    // 70-beat packet hits MAX_BEATS, then a clean packet
    build(p, 70, K7FFF, -1, '0, 1'b1);
    run_pkt(p, -1);
    build(p, 3, ALL1, -1, '0, 1'b1);
    run_pkt(p, -1);
    wait_drain();
    chk_cnt();

    // Illegal keep on beat 2 of 5, then a clean packet
    build(p, 5, K7FFF, 1, K7FFE, 1'b1);
    run_pkt(p, -1);
    build(p, 2, KW'(1), -1, '0, 1'b1);
    run_pkt(p, -1);
    // Illegal keep and MAX_BEATS on the same beat
    build(p, 66, K7FFF, MAXB - 1, K7FFE, 1'b1);
    run_pkt(p, -1);
    // Non-contiguous last keep
    build(p, 3, KW'(32'h5), -1, '0, 1'b1);
    run_pkt(p, -1);
    wait_drain();
    chk_cnt();

    // Link drops after beat 3 of 8; terminator, remainder dropped to tlast
    build(p, 8, K7FFF, -1, '0, 1'b1);
    run_pkt(p, 3);
    repeat (3) @(posedge clk);
    #1 rx_up = 1'b1;
    build(p, 4, K7FFF, -1, '0, 1'b1);
    run_pkt(p, -1);
    wait_drain();
    // Link drops with no tlast following; rx_up rise must end the discard
    build(p, 5, K7FFF, -1, '0, 1'b0);
    run_pkt(p, 3);
    repeat (3) @(posedge clk);
    #1 rx_up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    build(p, 3, K7FFF, -1, '0, 1'b1);
    run_pkt(p, -1);
    // rx_up falls in the cycle a legal tlast is accepted: normal close
    build(p, 2, K7FFF, -1, '0, 1'b1);
    model_pkt(p, -1);
    drive(p[0]);
    rx_up = 1'b0;
    drive(p[1]);
    repeat (3) @(posedge clk);
    #1 rx_up = 1'b1;
    wait_drain();
    chk_cnt();

    // Random legal traffic under 50% backpressure
    rdy_mode = 1'b1;
    total = 0;
    while (total < 1000) begin
      n = $urandom_range(1, 10);
      build(p, n, KW'((64'd1 << $urandom_range(1, KW)) - 64'd1), -1, '0, 1'b1);
      run_pkt(p, -1);
      total += n;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain();
    rdy_mode = 1'b0;
    @(posedge clk);
    #1;
    chk_cnt();

    // Asynchronous reset mid-packet
    mon_en = 1'b0;
    build(p, 6, K7FFF, -1, '0, 1'b1);
    for (int i = 0; i < 3; i++) drive(p[i]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid", m_if.tvalid, 1'b0);
    chk("arst_m_tdata", m_if.tdata, 256'(0));
    chk("arst_m_tkeep_last_user", {m_if.tkeep, m_if.tlast, m_if.tuser}, 256'(0));
    chk("arst_s_tready", s_if.tready, 1'b0);
    chk("arst_pkt_err", pkt_err, 1'b0);
    expq.delete();
    exp_pkt = 0;
    exp_err = 0;
    chk_cnt();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
    build(p, 4, K7FFF, -1, '0, 1'b1);
    run_pkt(p, -1);
    wait_drain();
    chk_cnt();
    chk("final_queue_empty", 256'(expq.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rifl_rx_pkt_guard.md
# rifl_rx_pkt_guard

Packet-integrity stage directly downstream of the RIFL receive lane's user buffer. It consumes the packed per-lane AXI-Stream (payload, keep, last), enforces packet framing rules and link-loss termination, and presents a registered, always-well-framed stream with a per-packet error marker to the user logic. It runs in the user/frame clock domain of the lane and adds one cycle of latency at full throughput.

## Interface
- PAYLOAD_WIDTH, 240, lane payload width in bits; multiple of 8
- MAX_BEATS, 64, maximum beats per packet; range 2..65535
- STAT_WIDTH, 32, width of statistics counters
- clk  in  1  frame clock, tx_frame_clk domain
- rst_n  in  1  reset; asynchronous, active-low
- rx_up  in  1  lane link-up status, synchronous to clk
- s_axis_tdata  in  PAYLOAD_WIDTH  input payload
- s_axis_tkeep  in  PAYLOAD_WIDTH/8  input byte enables
- s_axis_tlast  in  1  input end of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  PAYLOAD_WIDTH  output payload
- m_axis_tkeep  out  PAYLOAD_WIDTH/8  output byte enables
- m_axis_tlast  out  1  output end of packet
- m_axis_tuser  out  1  packet-bad marker, meaningful only with m_axis_tlast
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- pkt_err  out  1  one-cycle pulse per packet closed with tuser=1
- pkt_cnt  out  STAT_WIDTH  packets emitted (see Configuration)
- err_cnt  out  STAT_WIDTH  bad packets emitted (see Configuration)

## Operation
- Keep legality: non-last beat requires tkeep all ones; last beat requires tkeep = 2^n-1, 1 <= n <= PAYLOAD_WIDTH/8 (contiguous from LSB).
- FSM states: IDLE (between packets), PASS (inside packet), FLUSH (emit terminator), DROP (discard to input tlast).
- IDLE/PASS, accepted beat: beat counter increments (reset to 1 on first beat). Beat forwarded unchanged when legal.
  - legal tlast: forward, tuser=0, -> IDLE.
  - illegal keep on any beat: forward with tlast forced 1, tuser=1; -> IDLE if input tlast, else DROP.
  - beat count reaches MAX_BEATS without tlast: forward with tlast forced 1, tuser=1, -> DROP.
- PASS with rx_up low: -> FLUSH. FLUSH emits one beat tdata=0, tkeep=1, tlast=1, tuser=1; s_axis_tready=0 in FLUSH; -> DROP when terminator accepted by the output register.
- DROP: s_axis_tready=1, beats discarded; -> IDLE on accepted tlast, or on rx_up rising edge (new link session).
- IDLE with rx_up low: beats still forwarded normally (drain of good buffered data).
- Counters: pkt_cnt increments on every emitted tlast beat handshake; err_cnt when that beat has tuser=1; both saturate at all ones.

## Timing
- Reset (rst_n low, asynchronous): FSM IDLE, beat counter 0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0, s_axis_tready=0 until first clk after deassertion, then 1; pkt_err=0, counters 0.
- Output is a two-entry skid register: s_axis_tready is a register (no combinational path from m_axis_tready); first-beat latency 1 cycle; sustained 1 beat/cycle with m_axis_tready high.
- AXIS rules: m_axis_* stable while tvalid && !tready; tvalid never deasserted without handshake.
- pkt_err pulses the cycle the bad tlast beat handshakes on m_axis.
- Simultaneous: rx_up falls in the same cycle a legal tlast is accepted -> packet closes normally, no FLUSH. Illegal keep and MAX_BEATS on the same beat -> single terminated beat, counted once. rx_up falling in IDLE or DROP -> no terminator.
- rst_n asserted mid-packet: packet lost silently, no terminator emitted.

## Configuration
- RIFL_RX_PKT_STATS_EN defined: pkt_cnt and err_cnt implemented as specified.
- Undefined: pkt_cnt and err_cnt tied to 0, counter logic removed; pkt_err unaffected.

## Structure
- Package rifl_rx_pkt_pkg: FSM state enum, keep-legality function (parameterised on byte count), terminator tkeep constant.
- Sub-module rifl_axis_skid: generic two-entry register slice (data, keep, last, user), reused elsewhere in the lane.

## Test plan
- Three packets of 4 beats, last tkeep=0x7FFF, m_axis_tready=1 -> identical output, tuser=0, pkt_cnt=3, err_cnt=0, 1-cycle latency, no bubbles.
- Packet of 70 beats, MAX_BEATS=64 -> 64 beats out, beat 64 tlast=1 tuser=1, beats 65..70 dropped, pkt_err one pulse, err_cnt=1.
- Beat 2 of 5 with tkeep=0x7FFE -> beat 2 out with tlast=1 tuser=1, beats 3..5 dropped, next packet passes clean.
- rx_up drops after beat 3 of 8 -> terminator tdata=0 tkeep=0x0001 tlast=1 tuser=1; beats 4..8 dropped until tlast; with rx_up held low and no tlast, rx_up rise returns to IDLE.
- Random m_axis_tready (50%) over 1000 legal beats -> no loss/duplication, output stable under stall, s_axis_tready registered.
- rst_n pulsed low mid-packet asynchronously -> all outputs zero immediately, next packet passes with tuser=0.
